// File: rtl/pc_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit_if
// Bundles the fetch unit's datapath-facing signals: the next-PC loop, the
// instruction-memory req/ack channel and the decode hand-off.
//
// Handshake semantics (both channels):
//   - Memory channel: ImemReq is held high with a stable ImemAddr until a
//     clock edge where ImemAck is also high. ImemData is captured on that
//     same edge. ImemAck is ignored whenever ImemReq is low.
//   - Decode channel: InstrValid stays high with stable Instruction and
//     InstrPC until a clock edge where InstrAccept is also high. That edge
//     consumes the instruction. InstrAccept is ignored while InstrValid is low.
//
// Modports:
//   master - the fetch unit. It drives the PC, the fetch request and the held
//            instruction.
//   slave  - the surroundings. They drive NextPC, the memory response and the
//            decode accept.
// ---------------------------------------------------------------------------
interface pc_fetch_unit_if;
    logic [31:0] NextPC;
    logic [31:0] CurrentPC;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemData;
    logic        InstrValid;
    logic [31:0] Instruction;
    logic [31:0] InstrPC;
    logic        InstrAccept;
    logic [1:0]  FaultCode;
    logic [31:0] InstrCount;

    modport master (
        input  NextPC, ImemAck, ImemData, InstrAccept,
        output CurrentPC, ImemReq, ImemAddr, InstrValid, Instruction,
               InstrPC, FaultCode, InstrCount
    );

    modport slave (
        output NextPC, ImemAck, ImemData, InstrAccept,
        input  CurrentPC, ImemReq, ImemAddr, InstrValid, Instruction,
               InstrPC, FaultCode, InstrCount
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
// Program-counter register and instruction-fetch sequencer. It fetches the
// word at CurrentPC, holds it for decode, and on accept loads NextPC. On a
// misaligned NextPC or a memory timeout it records a sticky fault and halts.
// Only Reset leaves the halt.
//
// Ports:
//   CLK       - clock; all state changes on the rising edge.
//   Reset     - synchronous, active-high reset.
//   bus       - pc_fetch_unit_if.master: NextPC/CurrentPC loop, Imem
//               req/ack, decode valid/accept, FaultCode, InstrCount.
//   dbg_state - current FSM state (0 FETCH, 1 HOLD, 2 HALT) for observation.
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic                   CLK,
    input  logic                   Reset,
    pc_fetch_unit_if.master        bus,
    output logic [1:0]             dbg_state
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ALIGN   = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    // The wait counter value seen on the last request cycle that may still
    // go unacknowledged. An unacked edge at this value raises the timeout.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic [1:0]  fault_q, fault_d;
    logic [31:0] count_q, count_d;
    logic [7:0]  wait_q, wait_d;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            ipc_q   <= 32'h0;
            fault_q <= FAULT_NONE;
            count_q <= 32'h0;
            wait_q  <= 8'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            fault_q <= fault_d;
            count_q <= count_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        fault_d = fault_q;
        count_d = count_q;
        wait_d  = wait_q;

        case (state_q)
            ST_FETCH: begin
                if (bus.ImemAck) begin
                    instr_d = bus.ImemData;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    wait_d  = 8'h0;
                    state_d = ST_HOLD;
                end else if (wait_q == WAIT_LAST) begin
                    fault_d = FAULT_TIMEOUT;
                    state_d = ST_HALT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_HOLD: begin
                // The instruction is consumed even when its successor is
                // misaligned. Only the PC load is refused in that case.
                if (bus.InstrAccept) begin
                    count_d = count_q + 32'd1;
                    valid_d = 1'b0;
                    if (bus.NextPC[1:0] == 2'b00) begin
                        pc_d    = bus.NextPC;
                        state_d = ST_FETCH;
                    end else begin
                        fault_d = FAULT_ALIGN;
                        state_d = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // The request and address are decoded from state so that a 0-wait
    // memory can answer in the first request cycle.
    assign bus.ImemReq     = (state_q == ST_FETCH);
    assign bus.ImemAddr    = pc_q;
    assign bus.CurrentPC   = pc_q;
    assign bus.InstrValid  = valid_q;
    assign bus.Instruction = instr_q;
    assign bus.InstrPC     = ipc_q;
    assign bus.FaultCode   = fault_q;
    assign bus.InstrCount  = count_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
// Self-checking bench for pc_fetch_unit with the default parameters
// (RESET_PC = 0, TIMEOUT = 16). Inputs are driven on the falling edge and
// outputs are checked on the next falling edge.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [1:0] dbg_state;

  pc_fetch_unit_if bus();

  pc_fetch_unit dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, then move to the next falling edge.
  task automatic step(input logic rst, input logic ack, input logic [31:0] data,
                      input logic acc, input logic [31:0] npc);
    Reset           = rst;
    bus.ImemAck     = ack;
    bus.ImemData    = data;
    bus.InstrAccept = acc;
    bus.NextPC      = npc;
    @(negedge CLK);
  endtask

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] data;
    logic        acc;
    logic [31:0] npc;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [1:0]  fault;
    logic [31:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic ack, input logic [31:0] data,
                              input logic acc, input logic [31:0] npc,
                              input logic req, input logic [31:0] addr, input logic vld,
                              input logic [31:0] instr, input logic [31:0] ipc,
                              input logic [1:0] fault, input logic [31:0] cnt);
    vec_t v;
    v.rst = rst; v.ack = ack; v.data = data; v.acc = acc; v.npc = npc;
    v.req = req; v.addr = addr; v.vld = vld; v.instr = instr; v.ipc = ipc;
    v.fault = fault; v.cnt = cnt;
    return v;
  endfunction

  localparam int NV = 14;
  vec_t vt[NV];

  logic [63:0] exp_q[$];
  int          req_cycles;
  logic [31:0] held;

  initial begin
    Reset = 1'b1; bus.ImemAck = 1'b0; bus.ImemData = '0; bus.InstrAccept = 1'b0; bus.NextPC = '0;

    // Expected outputs are those seen after the edge that applies the inputs.
    //          rst ack data           acc npc            req addr   vld instr          ipc    flt cnt
    vt[0]  = mk(1, 1, 32'hDEAD_BEEF, 1, 32'h100,        1, 32'h0,  0, 32'h0,         32'h0,  0, 0);
    vt[1]  = mk(0, 1, 32'hA000_0000, 0, 32'h4,          0, 32'h0,  1, 32'hA000_0000, 32'h0,  0, 0);
    vt[2]  = mk(0, 0, 32'h0,         1, 32'h4,          1, 32'h4,  0, 32'hA000_0000, 32'h0,  0, 1);
    vt[3]  = mk(0, 1, 32'hA000_0001, 0, 32'h8,          0, 32'h4,  1, 32'hA000_0001, 32'h4,  0, 1);
    vt[4]  = mk(0, 1, 32'hBAD0_BAD0, 0, 32'h8,          0, 32'h4,  1, 32'hA000_0001, 32'h4,  0, 1);
    vt[5]  = mk(0, 0, 32'h0,         1, 32'h8,          1, 32'h8,  0, 32'hA000_0001, 32'h4,  0, 2);
    vt[6]  = mk(0, 0, 32'h0,         1, 32'h20,         1, 32'h8,  0, 32'hA000_0001, 32'h4,  0, 2);
    vt[7]  = mk(0, 1, 32'hA000_0002, 0, 32'hC,          0, 32'h8,  1, 32'hA000_0002, 32'h8,  0, 2);
    vt[8]  = mk(0, 0, 32'h0,         1, 32'hC,          1, 32'hC,  0, 32'hA000_0002, 32'h8,  0, 3);
    vt[9]  = mk(0, 1, 32'hA000_0003, 0, 32'h10,         0, 32'hC,  1, 32'hA000_0003, 32'hC,  0, 3);
    vt[10] = mk(0, 0, 32'h0,         1, 32'h10,         1, 32'h10, 0, 32'hA000_0003, 32'hC,  0, 4);
    vt[11] = mk(0, 1, 32'hA000_0004, 0, 32'h14,         0, 32'h10, 1, 32'hA000_0004, 32'h10, 0, 4);
    vt[12] = mk(0, 1, 32'h0,         1, 32'h0040_0102,  0, 32'h10, 0, 32'hA000_0004, 32'h10, 1, 5);
    vt[13] = mk(0, 1, 32'hFF,        1, 32'h8,          0, 32'h10, 0, 32'hA000_0004, 32'h10, 1, 5);

    @(negedge CLK);
    for (int i = 0; i < NV; i++) begin
      step(vt[i].rst, vt[i].ack, vt[i].data, vt[i].acc, vt[i].npc);
      check32($sformatf("vec%0d_req", i),   32'(bus.ImemReq),    32'(vt[i].req));
      check32($sformatf("vec%0d_addr", i),  bus.ImemAddr,        vt[i].addr);
      check32($sformatf("vec%0d_pc", i),    bus.CurrentPC,       vt[i].addr);
      check32($sformatf("vec%0d_vld", i),   32'(bus.InstrValid), 32'(vt[i].vld));
      check32($sformatf("vec%0d_instr", i), bus.Instruction,     vt[i].instr);
      check32($sformatf("vec%0d_ipc", i),   bus.InstrPC,         vt[i].ipc);
      check32($sformatf("vec%0d_fault", i), 32'(bus.FaultCode),  32'(vt[i].fault));
      check32($sformatf("vec%0d_cnt", i),   bus.InstrCount,      vt[i].cnt);
    end

    // Halted after the misaligned accept: stray acks must not restart fetching.
    for (int k = 0; k < 20; k++) begin
      step(0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 32'h4);
      check32("halt_req", 32'(bus.ImemReq), 32'h0);
      check32("halt_pc", bus.CurrentPC, 32'h10);
      check32("halt_fault", 32'(bus.FaultCode), 32'h1);
    end
    step(1, 0, 0, 0, 0);
    check32("rst_after_halt_addr", bus.ImemAddr, 32'h0);
    check32("rst_after_halt_fault", 32'(bus.FaultCode), 32'h0);
    check32("rst_after_halt_req", 32'(bus.ImemReq), 32'h1);

    // Three request cycles before the ack, then decode stalls for five cycles.
    req_cycles = 0;
    for (int k = 0; k < 3; k++) begin
      if (bus.ImemReq) req_cycles++;
      step(0, k == 2, 32'h1234_5678, 0, 32'h4);
    end
    check32("wait_req_cycles", 32'(req_cycles), 32'd3);
    check32("wait_req_low", 32'(bus.ImemReq), 32'h0);
    check32("wait_valid", 32'(bus.InstrValid), 32'h1);
    for (int k = 0; k < 5; k++) begin
      step(0, 1'($urandom_range(0, 1)), $urandom, 0, 32'h4);
      check32("stall_instr", bus.Instruction, 32'h1234_5678);
      check32("stall_pc", bus.CurrentPC, 32'h0);
      check32("stall_req", 32'(bus.ImemReq), 32'h0);
    end
    step(0, 0, 0, 1, 32'h4);
    check32("stall_accept_pc", bus.CurrentPC, 32'h4);
    check32("stall_accept_req", 32'(bus.ImemReq), 32'h1);
    check32("stall_accept_cnt", bus.InstrCount, 32'h1);

    // Reset in HOLD together with an accept: reset wins.
    step(0, 1, 32'h5555_AAAA, 0, 32'h8);
    step(1, 0, 0, 1, 32'h100);
    check32("rst_hold_pc", bus.CurrentPC, 32'h0);
    check32("rst_hold_valid", 32'(bus.InstrValid), 32'h0);
    check32("rst_hold_cnt", bus.InstrCount, 32'h0);
    check32("rst_hold_instr", bus.Instruction, 32'h0);

    // Instruction counter wraps.
    step(0, 1, 32'h0BAD_F00D, 0, 32'h4);
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    check32("wrap_preload", bus.InstrCount, 32'hFFFF_FFFF);
    step(0, 0, 0, 1, 32'h4);
    check32("wrap_cnt", bus.InstrCount, 32'h0);
    check32("wrap_fault", 32'(bus.FaultCode), 32'h0);

    // Memory never answers: 16 request cycles, then a timeout fault.
    step(1, 0, 0, 0, 0);
    req_cycles = 0;
    for (int k = 0; k < 40 && bus.ImemReq; k++) begin
      req_cycles++;
      step(0, 0, 0, 1, 32'h4);
    end
    check32("timeout_req_cycles", 32'(req_cycles), 32'd16);
    check32("timeout_fault", 32'(bus.FaultCode), 32'h2);
    check32("timeout_req_low", 32'(bus.ImemReq), 32'h0);
    step(1, 0, 0, 0, 0);
    check32("timeout_rst_addr", bus.ImemAddr, 32'h0);
    check32("timeout_rst_fault", 32'(bus.FaultCode), 32'h0);

    // Random traffic against a transaction-level model: every word the
    // memory hands over must reach decode in order, tagged with its address.
    begin
      logic [31:0] m_pc, npc, data;
      logic        m_fetch, ack, acc;
      int          m_cnt, wait_k, lat;
      m_pc = 32'h0; m_fetch = 1'b1; m_cnt = 0; wait_k = 0; lat = $urandom_range(0, 5);
      exp_q.delete();
      for (int cyc = 0; cyc < 2000; cyc++) begin
        check32("rnd_addr", bus.ImemAddr, m_pc);
        check32("rnd_req", 32'(bus.ImemReq), 32'(m_fetch));
        check32("rnd_valid", 32'(bus.InstrValid), 32'(!m_fetch));
        check32("rnd_fault", 32'(bus.FaultCode), 32'h0);
        if (!m_fetch) begin
          if (exp_q.size() == 0) begin
            check32("rnd_queue_empty", 32'(exp_q.size()), 32'd1);
          end else begin
            held = exp_q[0][31:0];
            check32("rnd_instr", bus.Instruction, held);
            check32("rnd_ipc", bus.InstrPC, exp_q[0][63:32]);
          end
        end
        data = $urandom;
        npc  = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : (m_pc + 32'd4);
        ack  = 1'b0;
        acc  = 1'b0;
        if (m_fetch) begin
          acc = 1'($urandom_range(0, 1));
          if (wait_k == lat) begin
            ack = 1'b1;
            exp_q.push_back({m_pc, data});
            m_fetch = 1'b0;
          end else begin
            wait_k++;
          end
        end else begin
          ack = 1'($urandom_range(0, 1));
          acc = ($urandom_range(0, 2) == 0);
          if (acc) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            m_cnt++;
            m_pc    = npc;
            m_fetch = 1'b1;
            wait_k  = 0;
            lat     = $urandom_range(0, 5);
          end
        end
        step(0, ack, data, acc, npc);
      end
      check32("rnd_count", bus.InstrCount, 32'(m_cnt));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
